// File: rtl/prod_accum_pkg.sv
// Shared definitions for the product accumulator: FSM state encoding and
// default widths for the accumulator and the run-length counter.
package prod_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_e;

  localparam int ACC_W_DEF = 6;
  localparam int CNT_W_DEF = 4;

endpackage

// File: rtl/prod_accum_ctrl.sv
// Run controller for prod_accum: IDLE/ACCUM/DONE FSM plus the remaining-count
// register. Emits load (start accepted) and xfer (product consumed) strobes
// that drive the datapath in the top level.
module prod_accum_ctrl
  import prod_accum_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic             in_ready,
  output logic             out_valid,
  output logic             busy,
  output logic             load,
  output logic             xfer
);

  state_e           state_q, state_d;
  // One extra bit so that len=0 can represent a full 2^CNT_W run.
  logic [CNT_W:0]   rem_q, rem_d;

  // State and remaining-count registers; reset returns to IDLE immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state logic and Moore-style handshake outputs.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    load      = 1'b0;
    xfer      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          rem_d   = (len == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, len};
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid) begin
          xfer  = 1'b1;
          rem_d = rem_q - (CNT_W+1)'(1);
          if (rem_q == (CNT_W+1)'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        // start is deliberately not looked at here; a new run begins in IDLE.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/prod_accum.sv
// Product accumulator: sums a run of 4-bit products into an ACC_W-bit
// accumulator with a sticky overflow flag.
// Build option: define PROD_ACCUM_SAT_EN to saturate acc to all-ones on
// overflow; otherwise acc wraps modulo 2^ACC_W. ovf behaves the same either way.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [3:0]       prod,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf,
  output logic             busy
);

  logic             load;
  logic             xfer;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum_w;

  prod_accum_ctrl #(
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .busy      (busy),
    .load      (load),
    .xfer      (xfer)
  );

  // One bit wider than acc so the carry out of the top bit is visible.
  assign sum_w = {1'b0, acc_q} + {{(ACC_W-3){1'b0}}, prod};

  // Accumulator next value: clear on run start, add on each transfer.
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (load) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (xfer) begin
      ovf_d = ovf_q | sum_w[ACC_W];
`ifdef PROD_ACCUM_SAT_EN
      // Once overflowed, pin at all-ones for the remainder of the run.
      acc_d = (ovf_q || sum_w[ACC_W]) ? '1 : sum_w[ACC_W-1:0];
`else
      acc_d = sum_w[ACC_W-1:0];
`endif
    end
  end

  // Accumulator and overflow registers; results persist in IDLE until next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc = acc_q;
  assign ovf = ovf_q;

endmodule
